// File: rtl/cla_subtractor_seq.sv
// ---------------------------------------------------------------------------
// cla_subtractor_seq
//   Sequential N-bit subtractor: diff = a - b, computed as a + ~b + 1 one
//   4-bit slice per cycle through a single carry_look_ahead_4bit instance.
//   The carry out of each slice is registered and fed into the next slice.
//   The final carry out is inverted to give the unsigned borrow.
//
//   Handshake (both sides): a transfer happens on a rising clk_in edge where
//   valid and ready are both 1. The producer holds its data stable while
//   valid is 1. The upstream side is ready only in IDLE. The downstream side
//   sees valid_out only in HOLD, and the result stays stable until ready_in
//   is sampled high.
//
//   Optional feature: define CLA_SUB_OVERFLOW_EN to add the ovf_out port and
//   the signed-overflow flag. Without it, neither the port nor the logic
//   exists.
//
// Ports
//   clk_in        in   1  clock, rising edge
//   rst_in        in   1  synchronous active-high reset
//   valid_in      in   1  operands valid
//   ready_out     out  1  block can accept operands (IDLE)
//   a_in          in   N  minuend
//   b_in          in   N  subtrahend
//   valid_out     out  1  diff_out/borrow_out valid (HOLD)
//   ready_in      in   1  consumer accepts result
//   diff_out      out  N  a - b modulo 2^N
//   borrow_out    out  1  1 iff a < b (unsigned)
//   ovf_out       out  1  signed overflow (CLA_SUB_OVERFLOW_EN only)
//   state_dbg_out out  2  current FSM state (IDLE=0, CALC=1, HOLD=2)
// ---------------------------------------------------------------------------

// 4-bit carry-lookahead adder slice
module carry_look_ahead_4bit (
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    input  logic       c_in,
    output logic [3:0] sum_out,
    output logic       c_out
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_in & b_in;
    assign p = a_in ^ b_in;

    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum_out = p ^ c[3:0];
    assign c_out   = c[4];
endmodule

module cla_subtractor_seq #(
    parameter int N = 16
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         valid_in,
    output logic         ready_out,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic         valid_out,
    input  logic         ready_in,
    output logic [N-1:0] diff_out,
    output logic         borrow_out,
`ifdef CLA_SUB_OVERFLOW_EN
    output logic         ovf_out,
`endif
    output logic [1:0]   state_dbg_out
);
    localparam int SLICES = N / 4;
    localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

    if ((N % 4) != 0 || N < 4) begin : g_bad_n
        $error("cla_subtractor_seq: N must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  nb_q, nb_d;      // subtrahend stored already inverted
    logic [N-1:0]  diff_q, diff_d;
    logic          borrow_q, borrow_d;
    logic          carry_q, carry_d;
    logic [KW-1:0] k_q, k_d;
`ifdef CLA_SUB_OVERFLOW_EN
    logic          ovf_q, ovf_d;
`endif

    logic [3:0] slice_a;
    logic [3:0] slice_nb;
    logic [3:0] slice_sum;
    logic       slice_c;

    assign slice_a  = a_q[k_q*4 +: 4];
    assign slice_nb = nb_q[k_q*4 +: 4];

    carry_look_ahead_4bit u_cla (
        .a_in    (slice_a),
        .b_in    (slice_nb),
        .c_in    (carry_q),
        .sum_out (slice_sum),
        .c_out   (slice_c)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            a_q      <= '0;
            nb_q     <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            carry_q  <= 1'b1;
            k_q      <= '0;
`ifdef CLA_SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            nb_q     <= nb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            carry_q  <= carry_d;
            k_q      <= k_d;
`ifdef CLA_SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        nb_d     = nb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        carry_d  = carry_q;
        k_d      = k_q;
`ifdef CLA_SUB_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    a_d      = a_in;
                    nb_d     = ~b_in;
                    diff_d   = '0;
                    borrow_d = 1'b0;
                    carry_d  = 1'b1;   // the +1 of the two's complement
                    k_d      = '0;
`ifdef CLA_SUB_OVERFLOW_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = CALC;
                end
            end
            CALC: begin
                diff_d[k_q*4 +: 4] = slice_sum;
                carry_d            = slice_c;
                if (k_q == K_LAST) begin
                    // No carry out of the top slice means a < b.
                    borrow_d = ~slice_c;
`ifdef CLA_SUB_OVERFLOW_EN
                    // Operand signs differ and the result sign differs from a.
                    ovf_d    = (a_q[N-1] ^ ~nb_q[N-1]) & (a_q[N-1] ^ slice_sum[3]);
`endif
                    state_d  = HOLD;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            HOLD: begin
                if (ready_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready_out     = (state_q == IDLE);
    assign valid_out     = (state_q == HOLD);
    assign diff_out      = diff_q;
    assign borrow_out    = borrow_q;
    assign state_dbg_out = state_q;
`ifdef CLA_SUB_OVERFLOW_EN
    assign ovf_out       = ovf_q;
`endif
endmodule

// File: tb/tb_cla_subtractor_seq.sv
module tb_cla_subtractor_seq;
  localparam int N = 16;
  localparam int LAT = N / 4;

  // clock / reset
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  logic         valid_in = 1'b0;
  logic         ready_out;
  logic [N-1:0] a_in = '0;
  logic [N-1:0] b_in = '0;
  logic         valid_out;
  logic         ready_in = 1'b1;
  logic [N-1:0] diff_out;
  logic         borrow_out;
  logic         ovf_out;
  logic [1:0]   state_dbg_out;

`ifndef CLA_SUB_OVERFLOW_EN
  assign ovf_out = 1'b0;
`endif

  cla_subtractor_seq #(.N(N)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .a_in          (a_in),
    .b_in          (b_in),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .diff_out      (diff_out),
    .borrow_out    (borrow_out),
`ifdef CLA_SUB_OVERFLOW_EN
    .ovf_out       (ovf_out),
`endif
    .state_dbg_out (state_dbg_out)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] diff;
    logic         borrow;
    logic         ovf;
    int           hold;
  } vec_t;

  vec_t vecs[8];

  // scoreboard
  logic [N:0] exp_q[$];     // {borrow, diff}
  logic       exp_ovf_q[$];
  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one operation, push its expectation, then wait for and check the result.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] e_diff, input logic e_borrow,
                        input logic e_ovf, input int hold);
    int lat;
    logic busy_ok;
    logic stable;
    logic [N-1:0] held;
    logic [N:0] e;
    logic eo;
    lat = 0;
    while (!ready_out && lat < 20) begin
      @(posedge clk_in); #1; lat++;
    end
    check("ready_before_accept", ready_out, 1);
    a_in = a;
    b_in = b;
    valid_in = 1'b1;
    ready_in = (hold == 0);
    exp_q.push_back({e_borrow, e_diff});
    exp_ovf_q.push_back(e_ovf);
    @(posedge clk_in); #1;
    // Keep valid_in high and scramble operands: both must be ignored in CALC.
    a_in = N'($urandom_range(0, 65535));
    b_in = N'($urandom_range(0, 65535));
    lat = 0;
    busy_ok = 1'b1;
    while (!valid_out && lat < 20) begin
      if (ready_out) busy_ok = 1'b0;
      @(posedge clk_in); #1; lat++;
    end
    valid_in = 1'b0;
    check("latency", lat, LAT);
    check("ready_low_in_calc", busy_ok, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      eo = exp_ovf_q.pop_front();
      check("diff", diff_out, e[N-1:0]);
      check("borrow", borrow_out, e[N]);
`ifdef CLA_SUB_OVERFLOW_EN
      check("ovf", ovf_out, eo);
`endif
    end
    check("ready_low_in_hold", ready_out, 0);
    if (hold > 0) begin
      held = diff_out;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk_in); #1;
        if (!valid_out || ready_out || diff_out !== held) stable = 1'b0;
      end
      check("hold_stable", stable, 1);
      ready_in = 1'b1;
    end
    @(posedge clk_in); #1;
    check("valid_drop", valid_out, 0);
    check("ready_back", ready_out, 1);
  endtask

  initial begin
    logic [N:0] full;
    logic [N-1:0] ra, rb, rd;
    logic ro;
    logic no_valid;

    vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 0};
    vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 0};
    vecs[2] = '{16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b0, 0};
    vecs[3] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 0};
    vecs[4] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 0};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 0};
    vecs[6] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 0};
    vecs[7] = '{16'h5555, 16'hAAAA, 16'hAAAB, 1'b1, 1'b1, 10};

    // reset
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    check("rst_ready", ready_out, 1);
    check("rst_valid", valid_out, 0);
    check("rst_diff", diff_out, 0);
    check("rst_borrow", borrow_out, 0);
    check("rst_ovf", ovf_out, 0);
    check("rst_state", state_dbg_out, 0);

    // table vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, vecs[i].ovf, vecs[i].hold);
    end

    // random operands against a reference model
    for (int i = 0; i < 8; i++) begin
      ra = N'($urandom_range(0, 65535));
      rb = N'($urandom_range(0, 65535));
      full = {1'b0, ra} - {1'b0, rb};
      rd = full[N-1:0];
      ro = (ra[N-1] ^ rb[N-1]) & (ra[N-1] ^ rd[N-1]);
      run_op(ra, rb, rd, full[N], ro, (i == 3) ? 2 : 0);
    end

    // reset during the second CALC cycle
    a_in = 16'h00FF;
    b_in = 16'h0F00;
    valid_in = 1'b1;
    @(posedge clk_in); #1;   // accept
    valid_in = 1'b0;
    @(posedge clk_in); #1;   // slice 0 done
    check("mid_calc_state", state_dbg_out, 1);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    check("midrst_ready", ready_out, 1);
    check("midrst_valid", valid_out, 0);
    check("midrst_diff", diff_out, 0);
    check("midrst_borrow", borrow_out, 0);
    check("midrst_ovf", ovf_out, 0);
    no_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_in); #1;
      if (valid_out) no_valid = 1'b0;
    end
    check("midrst_no_valid", no_valid, 1);

    // block works again after reset
    run_op(vecs[0].a, vecs[0].b, vecs[0].diff, vecs[0].borrow, vecs[0].ovf, 0);

    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
